// File: rtl/retire_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : retire_monitor
//  Purpose  : Observes the retire stream of a 16-bit core, classifies each
//             retiring instruction into an event kind, tags it with a running
//             instruction number and buffers it in a small FIFO for an
//             external consumer (valid/ready handshake). Counts retired
//             instructions, optionally counts cycles, tracks halt and a sticky
//             overflow flag for events lost to a full FIFO.
//
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             ret_*              - retire stream (valid, pc, attributes, data)
//             ev_valid/ev_ready  - event FIFO head handshake
//             ev_kind .. ev_mem_data - head event fields (zero when empty)
//             inst_count         - retired instruction counter (16 bit, wraps)
//             cycle_count        - running cycle counter (32 bit)
//             halted             - a HALT has retired; drain-only from then on
//             overflow           - sticky: an accepted retire was dropped
//
//  Options  : `define RETIRE_MONITOR_CYCLE_CNT_EN to build the cycle counter;
//             without it cycle_count is tied to zero.
//
//  Revision : 1.0  initial release
// ============================================================================
module retire_monitor #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ret_valid,
    input  logic [15:0] ret_pc,
    input  logic        ret_reg_wr,
    input  logic        ret_mem_rd,
    input  logic        ret_mem_wr,
    input  logic        ret_halt,
    input  logic [2:0]  ret_wr_reg,
    input  logic [15:0] ret_wr_data,
    input  logic [15:0] ret_mem_addr,
    input  logic [15:0] ret_mem_data,

    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [2:0]  ev_kind,
    output logic [15:0] ev_inum,
    output logic [15:0] ev_pc,
    output logic [2:0]  ev_reg,
    output logic [15:0] ev_reg_data,
    output logic [15:0] ev_addr,
    output logic [15:0] ev_mem_data,

    output logic [15:0] inst_count,
    output logic [31:0] cycle_count,
    output logic        halted,
    output logic        overflow
);

    localparam int              C_AW       = $clog2(DEPTH);
    localparam logic [C_AW-1:0] C_PTR_ONE  = 1;
    localparam logic [C_AW:0]   C_FULL_CNT = (C_AW+1)'(DEPTH);

    localparam logic [2:0] C_KIND_NOP  = 3'd0;
    localparam logic [2:0] C_KIND_REG  = 3'd1;
    localparam logic [2:0] C_KIND_LD   = 3'd2;
    localparam logic [2:0] C_KIND_ST   = 3'd3;
    localparam logic [2:0] C_KIND_STU  = 3'd4;
    localparam logic [2:0] C_KIND_HALT = 3'd5;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [2:0]  rgn;
        logic [15:0] reg_data;
        logic [15:0] addr;
        logic [15:0] mem_data;
    } event_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,      state_d;
    logic            halted_q,     halted_d;
    logic            overflow_q,   overflow_d;
    logic [15:0]     inst_count_q, inst_count_d;
    logic [C_AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [C_AW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [C_AW:0]   count_q,      count_d;

    // Event storage is data-only; emptiness is tracked by count_q, so the
    // array itself never needs a reset.
    event_t          fifo_q [DEPTH];

    logic            accept_w;
    logic            push_w;
    logic            pop_w;
    logic            full_w;
    logic            not_empty_w;
    event_t          new_ev_w;
    event_t          head_w;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        accept_w    = ret_valid && !halted_q;
        not_empty_w = (count_q != '0);
        full_w      = (count_q == C_FULL_CNT);
        pop_w       = not_empty_w && ev_ready;
        // A full FIFO can still take a retire if the head leaves this cycle.
        push_w      = accept_w && (!full_w || pop_w);

        // Kind priority: halt, store+update, store, load, reg write, other.
        if (ret_halt)                       new_ev_w.kind = C_KIND_HALT;
        else if (ret_reg_wr && ret_mem_wr)  new_ev_w.kind = C_KIND_STU;
        else if (ret_mem_wr)                new_ev_w.kind = C_KIND_ST;
        else if (ret_reg_wr && ret_mem_rd)  new_ev_w.kind = C_KIND_LD;
        else if (ret_reg_wr)                new_ev_w.kind = C_KIND_REG;
        else                                new_ev_w.kind = C_KIND_NOP;
        new_ev_w.inum     = inst_count_q;
        new_ev_w.pc       = ret_pc;
        new_ev_w.rgn      = ret_wr_reg;
        new_ev_w.reg_data = ret_wr_data;
        new_ev_w.addr     = ret_mem_addr;
        new_ev_w.mem_data = ret_mem_data;

        wr_ptr_d = push_w ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_w  ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;

        count_d = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Dropped retires still consume an instruction number.
        inst_count_d = accept_w ? (inst_count_q + 16'd1) : inst_count_q;
        overflow_d   = overflow_q || (accept_w && !push_w);

        state_d = state_q;
        case (state_q)
            ST_RUN:    if (accept_w && ret_halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    // ------------------------------------------------------------------
    // Control registers (FSM, counters, pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            halted_q     <= 1'b0;
            overflow_q   <= 1'b0;
            inst_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            halted_q     <= halted_d;
            overflow_q   <= overflow_d;
            inst_count_q <= inst_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            fifo_q[wr_ptr_q] <= new_ev_w;
        end
    end

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = halted_q ? cycle_q : (cycle_q + 32'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs: head fields are forced to zero while the FIFO is empty.
    // ------------------------------------------------------------------
    assign head_w      = not_empty_w ? fifo_q[rd_ptr_q] : '0;

    assign ev_valid    = not_empty_w;
    assign ev_kind     = head_w.kind;
    assign ev_inum     = head_w.inum;
    assign ev_pc       = head_w.pc;
    assign ev_reg      = head_w.rgn;
    assign ev_reg_data = head_w.reg_data;
    assign ev_addr     = head_w.addr;
    assign ev_mem_data = head_w.mem_data;

    assign inst_count  = inst_count_q;
    assign halted      = halted_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_retire_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_retire_monitor
//  Purpose  : Directed self-checking bench for retire_monitor (DEPTH = 4).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_retire_monitor;

    logic        clk;
    logic        rst;
    logic        ret_valid;
    logic [15:0] ret_pc;
    logic        ret_reg_wr, ret_mem_rd, ret_mem_wr, ret_halt;
    logic [2:0]  ret_wr_reg;
    logic [15:0] ret_wr_data, ret_mem_addr, ret_mem_data;
    logic        ev_valid, ev_ready;
    logic [2:0]  ev_kind;
    logic [15:0] ev_inum, ev_pc;
    logic [2:0]  ev_reg;
    logic [15:0] ev_reg_data, ev_addr, ev_mem_data;
    logic [15:0] inst_count;
    logic [31:0] cycle_count;
    logic        halted, overflow;

    int n_vec;
    int n_err;

    retire_monitor #(.DEPTH(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .ret_reg_wr   (ret_reg_wr),
        .ret_mem_rd   (ret_mem_rd),
        .ret_mem_wr   (ret_mem_wr),
        .ret_halt     (ret_halt),
        .ret_wr_reg   (ret_wr_reg),
        .ret_wr_data  (ret_wr_data),
        .ret_mem_addr (ret_mem_addr),
        .ret_mem_data (ret_mem_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_kind      (ev_kind),
        .ev_inum      (ev_inum),
        .ev_pc        (ev_pc),
        .ev_reg       (ev_reg),
        .ev_reg_data  (ev_reg_data),
        .ev_addr      (ev_addr),
        .ev_mem_data  (ev_mem_data),
        .inst_count   (inst_count),
        .cycle_count  (cycle_count),
        .halted       (halted),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic retire(input logic [15:0] pc, input logic rw, input logic mr,
                          input logic mw, input logic hl, input logic [2:0] wreg,
                          input logic [15:0] wdata, input logic [15:0] addr,
                          input logic [15:0] mdata);
        ret_valid    = 1'b1;
        ret_pc       = pc;
        ret_reg_wr   = rw;
        ret_mem_rd   = mr;
        ret_mem_wr   = mw;
        ret_halt     = hl;
        ret_wr_reg   = wreg;
        ret_wr_data  = wdata;
        ret_mem_addr = addr;
        ret_mem_data = mdata;
        tick();
        ret_valid    = 1'b0;
        ret_reg_wr   = 1'b0;
        ret_mem_rd   = 1'b0;
        ret_mem_wr   = 1'b0;
        ret_halt     = 1'b0;
    endtask

    // Pop exactly one event.
    task automatic pop_one();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] c0;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; ret_valid = 1'b0; ret_pc = '0;
        ret_reg_wr = 1'b0; ret_mem_rd = 1'b0; ret_mem_wr = 1'b0; ret_halt = 1'b0;
        ret_wr_reg = '0; ret_wr_data = '0; ret_mem_addr = '0; ret_mem_data = '0;
        ev_ready = 1'b0;

        // Reset state
        #1;
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_inst",     32'(inst_count), 32'd0);
        check("rst_cycle",    cycle_count, 32'd0);
        check("rst_halted",   32'(halted), 32'd0);
        check("rst_ovf",      32'(overflow), 32'd0);
        check("rst_kind",     32'(ev_kind), 32'd0);
        tick();
        rst = 1'b0;

        // Single REG retire, one-cycle latency
        do_reset();
        retire(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234, 16'h0, 16'h0);
        check("reg_valid", 32'(ev_valid), 32'd1);
        check("reg_kind",  32'(ev_kind), 32'd1);
        check("reg_inum",  32'(ev_inum), 32'd0);
        check("reg_reg",   32'(ev_reg), 32'd3);
        check("reg_data",  32'(ev_reg_data), 32'h1234);
        check("reg_pc",    32'(ev_pc), 32'h0002);
        tick();
        check("reg_hold_data", 32'(ev_reg_data), 32'h1234);
        pop_one();
        check("reg_popped", 32'(ev_valid), 32'd0);
        check("reg_zero_pc", 32'(ev_pc), 32'd0);
        check("reg_inst", 32'(inst_count), 32'd1);

        // Six retires into DEPTH=4 with consumer stalled
        do_reset();
        for (int i = 0; i < 6; i++)
            retire(16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'(i), 16'h0, 16'h0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_inst", 32'(inst_count), 32'd6);
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_drain_inum%0d", i), 32'(ev_inum), 32'(i));
            tick();
        end
        ev_ready = 1'b0;
        check("ovf_empty", 32'(ev_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 4; i++)
            retire(16'h0200 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
        check("full_ovf0", 32'(overflow), 32'd0);
        ev_ready = 1'b1;
        retire(16'h0204, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
        ev_ready = 1'b0;
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_inst", 32'(inst_count), 32'd5);
        ev_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check($sformatf("full_drain_inum%0d", i), 32'(ev_inum), 32'(i));
            tick();
        end
        ev_ready = 1'b0;
        check("full_empty", 32'(ev_valid), 32'd0);

        // Kind classification
        do_reset();
        retire(16'h0004, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 16'h5555, 16'h0040, 16'hBEEF);
        check("stu_kind", 32'(ev_kind), 32'd4);
        check("stu_addr", 32'(ev_addr), 32'h0040);
        check("stu_mdata", 32'(ev_mem_data), 32'hBEEF);
        check("stu_reg", 32'(ev_reg), 32'd5);
        check("stu_rdata", 32'(ev_reg_data), 32'h5555);
        pop_one();
        retire(16'h0006, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0077, 16'h0080, 16'h0);
        check("ld_kind", 32'(ev_kind), 32'd2);
        check("ld_inum", 32'(ev_inum), 32'd1);
        pop_one();
        retire(16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0090, 16'h1111);
        check("st_kind", 32'(ev_kind), 32'd3);
        pop_one();
        retire(16'h000A, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
        check("nop_kind", 32'(ev_kind), 32'd0);
        check("nop_valid", 32'(ev_valid), 32'd1);
        pop_one();

        // Halt: priority over other attributes, freezes acceptance
        do_reset();
        retire(16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0, 16'h0, 16'h0);
        check("halt_kind", 32'(ev_kind), 32'd5);
        check("halt_pc", 32'(ev_pc), 32'h0010);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_inst", 32'(inst_count), 32'd1);
`ifdef RETIRE_MONITOR_CYCLE_CNT_EN
        c0 = cycle_count;
        check("halt_cycle_nz", 32'(c0 != 32'd0), 32'd1);
`else
        c0 = 32'd0;
`endif
        retire(16'h0012, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0, 16'h0, 16'h0);
        retire(16'h0014, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0, 16'h0, 16'h0);
        check("halt_inst_frozen", 32'(inst_count), 32'd1);
        check("halt_head_inum", 32'(ev_inum), 32'd0);
        check("halt_cycle_frozen", cycle_count, c0);
        pop_one();
        check("halt_drained", 32'(ev_valid), 32'd0);
        check("halt_still", 32'(halted), 32'd1);
        check("halt_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++)
            retire(16'h0300 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h00AA, 16'h0, 16'h0);
        check("ar_valid_before", 32'(ev_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(ev_valid), 32'd0);
        check("ar_inst", 32'(inst_count), 32'd0);
        check("ar_pc", 32'(ev_pc), 32'd0);
        tick();
        rst = 1'b0;
        retire(16'h0400, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'h00BB, 16'h0, 16'h0);
        check("ar_new_inum", 32'(ev_inum), 32'd0);
        check("ar_new_pc", 32'(ev_pc), 32'h0400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
